// File: rtl/ncd_pkg.sv
// ---------------------------------------------------------------------------
// ncd_pkg
// Shared constants and helpers for the numeric code detonator front-end.
//   - Button bit positions inside btn_raw / btn_pulse.
//   - Lane counts for the digit keys and control buttons.
//   - Debounce lengths for simulation and for the board.
//   - Small helpers for one-hot detection and digit encoding.
// ---------------------------------------------------------------------------
package ncd_pkg;

   localparam int NUM_KEYS = 10;
   localparam int NUM_BTNS = 5;

   localparam int BTN_WAIT  = 0;
   localparam int BTN_SETUP = 1;
   localparam int BTN_READY = 2;
   localparam int BTN_FIRE  = 3;
   localparam int BTN_SURE  = 4;

   localparam int unsigned DEBOUNCE_SIM   = 2;
   localparam int unsigned DEBOUNCE_BOARD = 20;

   typedef logic [NUM_KEYS-1:0] keyVecT;
   typedef logic [NUM_BTNS-1:0] btnVecT;

   // True when exactly one bit of the digit vector is set.
   function automatic logic isOneHot(input keyVecT v);
      return (v != '0) && ((v & (v - 1'b1)) == '0);
   endfunction

   // Binary index of the set bit; only meaningful for a one-hot vector.
   function automatic logic [3:0] keyIndex(input keyVecT v);
      logic [3:0] idx;
      idx = 4'h0;
      for (int i = 0; i < NUM_KEYS; i++) begin
         if (v[i]) begin
            idx = 4'(i);
         end
      end
      return idx;
   endfunction

endpackage

// File: rtl/key_debounce.sv
// ---------------------------------------------------------------------------
// key_debounce
// One input lane: two-flop synchroniser, debounce counter, accepted stable
// level and a one-cycle registered rise pulse.
// Ports:
//   clk      in   system clock
//   rst      in   asynchronous active-low reset
//   raw_i    in   raw asynchronous, bouncy level
//   stable_o out  debounced level
//   rise_o   out  one-cycle pulse, high the cycle after a 0->1 acceptance
// ---------------------------------------------------------------------------
module key_debounce
   import ncd_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CNT = DEBOUNCE_BOARD,
   parameter int          CNT_W        = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic raw_i,
   output logic stable_o,
   output logic rise_o
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CNT - 1);

   logic             s1_q;
   logic             s2_q;
   logic             stable_q;
   logic             stable_d;
   logic             rise_q;
   logic             rise_d;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   // Counter runs only while the synchronised level disagrees with the
   // accepted level; any agreement (a bounce back) restarts it from zero.
   // It stops at CNT_LAST because reaching it always accepts the new level.
   always_comb begin
      stable_d = stable_q;
      cnt_d    = '0;
      rise_d   = 1'b0;
      if (s2_q != stable_q) begin
         if (cnt_q == CNT_LAST) begin
            stable_d = s2_q;
            rise_d   = s2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   // Synchroniser and debounce state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_q     <= 1'b0;
         s2_q     <= 1'b0;
         stable_q <= 1'b0;
         cnt_q    <= '0;
         rise_q   <= 1'b0;
      end else begin
         s1_q     <= raw_i;
         s2_q     <= s1_q;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
         rise_q   <= rise_d;
      end
   end

   assign stable_o = stable_q;
   assign rise_o   = rise_q;

endmodule

// File: rtl/key_input_conditioner.sv
// ---------------------------------------------------------------------------
// key_input_conditioner
// Front-end of the numeric code detonator. Debounces ten digit keys and five
// control buttons into clean clk-domain pulses and keeps the last accepted
// digit as a 4-bit code. Simultaneous digit activity is flagged, not passed.
// Ports:
//   clk        in   system clock
//   rst        in   asynchronous active-low reset
//   key_raw    in   raw digit keys 0-9, active-high
//   btn_raw    in   raw buttons {sure, fire, ready, setup, wait_t}
//   key_pulse  out  one-hot one-cycle pulse on an accepted digit
//   key_valid  out  one-cycle pulse alongside key_pulse
//   key_code   out  binary code of the last accepted digit
//   btn_pulse  out  one-cycle pulse per button press
//   multi_err  out  one-cycle pulse when more than one digit is active
// ---------------------------------------------------------------------------
module key_input_conditioner
   import ncd_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CNT = DEBOUNCE_BOARD,
   parameter int          CNT_W        = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] key_raw,
   input  logic [4:0] btn_raw,
   output logic [9:0] key_pulse,
   output logic       key_valid,
   output logic [3:0] key_code,
   output logic [4:0] btn_pulse,
   output logic       multi_err
);

   localparam int NUM_LANES = NUM_KEYS + NUM_BTNS;

   logic [NUM_LANES-1:0] laneRaw;
   logic [NUM_LANES-1:0] laneStable;
   logic [NUM_LANES-1:0] laneRise;
   keyVecT               digitRise;
   keyVecT               digitStable;
   logic                 digitAccept;
   logic [3:0]           keyCode_q;
   logic                 unusedBtnStable;

   assign laneRaw = {btn_raw, key_raw};

   // Lanes 0-9 are the digits, lanes 10-14 the buttons in btn_raw order.
   for (genvar g = 0; g < NUM_LANES; g++) begin : gLane
      key_debounce #(
         .DEBOUNCE_CNT (DEBOUNCE_CNT),
         .CNT_W        (CNT_W)
      ) uLane (
         .clk      (clk),
         .rst      (rst),
         .raw_i    (laneRaw[g]),
         .stable_o (laneStable[g]),
         .rise_o   (laneRise[g])
      );
   end

   assign digitRise   = laneRise[NUM_KEYS-1:0];
   assign digitStable = laneStable[NUM_KEYS-1:0];

   // A digit is accepted only when it is the sole rising digit and the only
   // digit held down; otherwise any rise is reported as a multi-press.
   always_comb begin
      digitAccept = isOneHot(digitRise) && (digitStable == digitRise);
      key_valid   = digitAccept;
      key_pulse   = digitAccept ? digitRise : '0;
      multi_err   = (digitRise != '0) && !digitAccept;
      key_code    = digitAccept ? keyIndex(digitRise) : keyCode_q;
   end

   assign btn_pulse = laneRise[NUM_LANES-1:NUM_KEYS];

   // Button debounced levels are not needed downstream.
   assign unusedBtnStable = ^laneStable[NUM_LANES-1:NUM_KEYS];

   // Holds the code so it stays visible after the accept cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         keyCode_q <= 4'h0;
      end else begin
         keyCode_q <= key_code;
      end
   end

endmodule

// File: tb/tb_key_input_conditioner.sv
// ---------------------------------------------------------------------------
// tb_key_input_conditioner
// Directed scoreboard bench for key_input_conditioner with DEBOUNCE_CNT=4.
// Stimulus pushes the expected pulse event (with its cycle) into a queue; a
// monitor pops and compares whenever the DUT shows any pulse.
// ---------------------------------------------------------------------------
module tb_key_input_conditioner;

   localparam int unsigned DEB = 4;

   typedef struct {
      logic [9:0] pulse;
      logic       valid;
      logic [3:0] code;
      logic [4:0] btn;
      logic       err;
      int         cycle;
   } expT;

   logic       clk;
   logic       rst;
   logic [9:0] key_raw;
   logic [4:0] btn_raw;
   logic [9:0] key_pulse;
   logic       key_valid;
   logic [3:0] key_code;
   logic [4:0] btn_pulse;
   logic       multi_err;

   int  cycleCount;
   int  assertCount;
   int  failCount;
   expT expQ[$];

   key_input_conditioner #(
      .DEBOUNCE_CNT (DEB),
      .CNT_W        (16)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .key_raw   (key_raw),
      .btn_raw   (btn_raw),
      .key_pulse (key_pulse),
      .key_valid (key_valid),
      .key_code  (key_code),
      .btn_pulse (btn_pulse),
      .multi_err (multi_err)
   );

   // Free-running clock and cycle counter used to time expected events.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cycleCount = 0;
   always @(posedge clk) cycleCount <= cycleCount + 1;

   task automatic checkOutput(input string name, input int actual, input int expected);
      assertCount++;
      if (actual != expected) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, actual, expected, cycleCount);
      end
   endtask

   task automatic applyStimulus(input logic [9:0] keys, input logic [4:0] btns);
      @(negedge clk);
      key_raw = keys;
      btn_raw = btns;
   endtask

   task automatic waitCycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Called right after applyStimulus/reset release: the event lands DEB+2
   // edges after the first sampling edge.
   task automatic expectEvent(input logic [9:0] pulse, input logic valid, input logic [3:0] code,
                              input logic [4:0] btn, input logic err);
      expT e;
      e.pulse = pulse;
      e.valid = valid;
      e.code  = code;
      e.btn   = btn;
      e.err   = err;
      e.cycle = cycleCount + int'(DEB) + 2;
      expQ.push_back(e);
   endtask

   // Monitor: any pulse-type activity must match the oldest expected event.
   always @(negedge clk) begin
      expT e;
      if (key_valid || multi_err || (key_pulse != '0) || (btn_pulse != '0)) begin
         if (expQ.size() == 0) begin
            assertCount++;
            failCount++;
            $display("[TB] FAIL unexpected_event: key_pulse=0x%0h key_valid=%0b btn_pulse=0x%0h multi_err=%0b expected none (cycle %0d)",
                     key_pulse, key_valid, btn_pulse, multi_err, cycleCount);
         end else begin
            e = expQ.pop_front();
            checkOutput("event_cycle", cycleCount, e.cycle);
            checkOutput("key_pulse", int'(key_pulse), int'(e.pulse));
            checkOutput("key_valid", int'(key_valid), int'(e.valid));
            checkOutput("key_code", int'(key_code), int'(e.code));
            checkOutput("btn_pulse", int'(btn_pulse), int'(e.btn));
            checkOutput("multi_err", int'(multi_err), int'(e.err));
         end
      end
   end

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_key_pulse"}, int'(key_pulse), 0);
      checkOutput({tag, "_key_valid"}, int'(key_valid), 0);
      checkOutput({tag, "_key_code"}, int'(key_code), 0);
      checkOutput({tag, "_btn_pulse"}, int'(btn_pulse), 0);
      checkOutput({tag, "_multi_err"}, int'(multi_err), 0);
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation still running, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      assertCount = 0;
      failCount   = 0;
      rst         = 1'b0;
      key_raw     = '0;
      btn_raw     = '0;
      waitCycles(3);
      checkAllZero("reset");
      @(negedge clk);
      rst = 1'b1;
      waitCycles(5);

      // T1: single digit 5 held.
      applyStimulus(10'h020, 5'b0);
      expectEvent(10'h020, 1'b1, 4'h5, 5'b0, 1'b0);
      waitCycles(20);
      checkOutput("t1_code_held", int'(key_code), 5);
      applyStimulus(10'h000, 5'b0);
      waitCycles(10);
      checkOutput("t1_code_after_release", int'(key_code), 5);

      // T2: digit 2 bounces, then settles high.
      applyStimulus(10'h004, 5'b0);
      applyStimulus(10'h000, 5'b0);
      applyStimulus(10'h004, 5'b0);
      applyStimulus(10'h000, 5'b0);
      applyStimulus(10'h004, 5'b0);
      expectEvent(10'h004, 1'b1, 4'h2, 5'b0, 1'b0);
      waitCycles(12);
      applyStimulus(10'h000, 5'b0);
      waitCycles(10);

      // T3: digits 2 and 8 together.
      applyStimulus(10'h104, 5'b0);
      expectEvent(10'h000, 1'b0, 4'h2, 5'b0, 1'b1);
      waitCycles(10);
      checkOutput("t3_code_kept", int'(key_code), 2);
      applyStimulus(10'h000, 5'b0);
      waitCycles(10);

      // T4: fire button with digit 0.
      applyStimulus(10'h001, 5'b01000);
      expectEvent(10'h001, 1'b1, 4'h0, 5'b01000, 1'b0);
      waitCycles(10);
      applyStimulus(10'h000, 5'b0);
      waitCycles(10);

      // T5: reset two cycles into a digit 7 debounce, key held through it.
      applyStimulus(10'h080, 5'b0);
      waitCycles(2);
      rst = 1'b0;
      waitCycles(1);
      checkAllZero("t5_in_reset");
      waitCycles(2);
      checkAllZero("t5_in_reset_late");
      @(negedge clk);
      rst = 1'b1;
      expectEvent(10'h080, 1'b1, 4'h7, 5'b0, 1'b0);
      waitCycles(12);
      checkOutput("t5_code_held", int'(key_code), 7);
      applyStimulus(10'h000, 5'b0);
      waitCycles(10);

      // T6: digit 9 held long, released, pressed again.
      applyStimulus(10'h200, 5'b0);
      expectEvent(10'h200, 1'b1, 4'h9, 5'b0, 1'b0);
      waitCycles(50);
      applyStimulus(10'h000, 5'b0);
      waitCycles(10);
      applyStimulus(10'h200, 5'b0);
      expectEvent(10'h200, 1'b1, 4'h9, 5'b0, 1'b0);
      waitCycles(10);
      applyStimulus(10'h000, 5'b0);
      waitCycles(10);

      checkOutput("pending_events", expQ.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
